// File: rtl/sched_wctl_unit.sv
// Scheduler-side receiver for warp-control requests (TMC, WSPAWN, BAR).
// Keeps the active-warp mask, per-warp thread masks and barrier arrival state,
// and drives the stall mask, the spawn pulse and the barrier-release pulse.
// Every output comes from a register, so inputs never reach outputs combinationally.
module sched_wctl_unit #(
   parameter int NUM_WARPS    = 4,
   parameter int NUM_THREADS  = 4,
   parameter int NUM_BARRIERS = 4,
   parameter int PC_WIDTH     = 32,
   parameter int NW_BITS      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
   parameter int NB_BITS      = (NUM_BARRIERS > 1) ? $clog2(NUM_BARRIERS) : 1
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             wctl_valid,
   input  logic [NW_BITS-1:0]               wctl_wid,
   input  logic                             tmc_valid,
   input  logic [NUM_THREADS-1:0]           tmc_tmask,
   input  logic                             wspawn_valid,
   input  logic [NUM_WARPS-1:0]             wspawn_wmask,
   input  logic [PC_WIDTH-1:0]              wspawn_pc,
   input  logic                             bar_valid,
   input  logic [NB_BITS-1:0]               bar_id,
   input  logic [NW_BITS-1:0]               bar_size_m1,
   output logic [NUM_WARPS-1:0]             active_warps,
   output logic [NUM_WARPS*NUM_THREADS-1:0] thread_masks,
   output logic [NUM_WARPS-1:0]             stalled_warps,
   output logic                             spawn_valid,
   output logic [NUM_WARPS-1:0]             spawn_wmask,
   output logic [PC_WIDTH-1:0]              spawn_pc,
   output logic                             bar_release
);

   logic [NUM_WARPS-1:0]   active_q, active_d;
   logic [NUM_WARPS-1:0]   stall_q, stall_d;
   logic [NUM_THREADS-1:0] tmask_q [NUM_WARPS];
   logic [NUM_THREADS-1:0] tmask_d [NUM_WARPS];
   logic [NW_BITS-1:0]     cnt_q   [NUM_BARRIERS];
   logic [NW_BITS-1:0]     cnt_d   [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]   bmask_q [NUM_BARRIERS];
   logic [NUM_WARPS-1:0]   bmask_d [NUM_BARRIERS];
   logic                   spawn_valid_q, spawn_valid_d;
   logic [NUM_WARPS-1:0]   spawn_wmask_q, spawn_wmask_d;
   logic [PC_WIDTH-1:0]    spawn_pc_q, spawn_pc_d;
   logic                   bar_release_q, bar_release_d;
   logic [NUM_WARPS-1:0]   spawn_eff;
   logic                   bar_dup;

   // Next-state decode: barrier bookkeeping first, then TMC, then spawn.
   always_comb begin
      active_d      = active_q;
      stall_d       = stall_q;
      tmask_d       = tmask_q;
      cnt_d         = cnt_q;
      bmask_d       = bmask_q;
      spawn_valid_d = 1'b0;
      spawn_wmask_d = spawn_wmask_q;
      spawn_pc_d    = spawn_pc_q;
      bar_release_d = 1'b0;
      // Warp 0 and warps already running are never (re)started.
      spawn_eff     = wspawn_wmask & ~active_q & ~NUM_WARPS'(1);
      // A warp arriving twice at the same barrier is dropped.
      bar_dup       = bmask_q[bar_id][wctl_wid];

      if (wctl_valid) begin
         if (bar_valid && !bar_dup) begin
            if (cnt_q[bar_id] == bar_size_m1) begin
               // Last arrival: free everyone waiting; the arriving warp never stalls.
               stall_d         = stall_q & ~bmask_q[bar_id];
               cnt_d[bar_id]   = '0;
               bmask_d[bar_id] = '0;
               bar_release_d   = 1'b1;
            end else begin
               cnt_d[bar_id]             = cnt_q[bar_id] + NW_BITS'(1);
               bmask_d[bar_id][wctl_wid] = 1'b1;
               stall_d[wctl_wid]         = 1'b1;
            end
         end

         if (tmc_valid) begin
            tmask_d[wctl_wid] = tmc_tmask;
            if (tmc_tmask == '0) begin
               active_d[wctl_wid] = 1'b0;
            end
         end

         if (wspawn_valid && (spawn_eff != '0)) begin
            active_d = active_d | spawn_eff;
            for (int w = 0; w < NUM_WARPS; w++) begin
               if (spawn_eff[w]) begin
                  tmask_d[w] = NUM_THREADS'(1);
               end
            end
            spawn_valid_d = 1'b1;
            spawn_wmask_d = spawn_eff;
            spawn_pc_d    = wspawn_pc;
         end
      end
   end

   // Warp-level state and the output pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         active_q      <= NUM_WARPS'(1);
         stall_q       <= '0;
         spawn_valid_q <= 1'b0;
         spawn_wmask_q <= '0;
         spawn_pc_q    <= '0;
         bar_release_q <= 1'b0;
      end else begin
         active_q      <= active_d;
         stall_q       <= stall_d;
         spawn_valid_q <= spawn_valid_d;
         spawn_wmask_q <= spawn_wmask_d;
         spawn_pc_q    <= spawn_pc_d;
         bar_release_q <= bar_release_d;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
         // Per-warp thread mask; only warp 0 starts with a live thread.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               tmask_q[gi] <= (gi == 0) ? NUM_THREADS'(1) : '0;
            end else begin
               tmask_q[gi] <= tmask_d[gi];
            end
         end
         assign thread_masks[gi*NUM_THREADS +: NUM_THREADS] = tmask_q[gi];
      end

      for (gi = 0; gi < NUM_BARRIERS; gi++) begin : g_bar
         // Per-barrier arrival count and arrival mask.
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               cnt_q[gi]   <= '0;
               bmask_q[gi] <= '0;
            end else begin
               cnt_q[gi]   <= cnt_d[gi];
               bmask_q[gi] <= bmask_d[gi];
            end
         end
      end
   endgenerate

   assign active_warps  = active_q;
   assign stalled_warps = stall_q;
   assign spawn_valid   = spawn_valid_q;
   assign spawn_wmask   = spawn_wmask_q;
   assign spawn_pc      = spawn_pc_q;
   assign bar_release   = bar_release_q;

   bar_no_dup_a: assert property (@(posedge clk) disable iff (!reset)
      !(wctl_valid && bar_valid && bmask_q[bar_id][wctl_wid]));

endmodule
